// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: shared constants for the frame-buffer plot arbiter.
// Holds the 160x120 frame geometry, coordinate/colour widths, the clear
// fill colour, the arbiter FSM state encoding and a range-check helper.
package vga_plot_pkg;

    localparam int XMAX = 160;
    localparam int YMAX = 120;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 9;

    localparam logic [CW-1:0] BG_COLOR = 9'h000;

    // Last raster coordinates and exclusive limits at their natural widths.
    localparam logic [XW-1:0] X_LAST = 8'd159;
    localparam logic [YW-1:0] Y_LAST = 7'd119;
    localparam logic [XW-1:0] X_LIM  = 8'd160;
    localparam logic [YW-1:0] Y_LIM  = 7'd120;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    // True when a requested pixel lies inside the visible frame.
    function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < X_LIM) && (y < Y_LIM);
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: requester handshakes and the frame-buffer write bus.
//   req0_*  snake pixel request (valid/ready + x, y, colour)
//   req1_*  overlay pixel request (valid/ready + x, y, colour)
//   VGA_*   registered pixel write toward the VGA adapter
// master: game side (drives requests, observes grants and writes)
// slave : arbiter side
interface vga_plot_arbiter_if;
    import vga_plot_pkg::*;

    logic          req0_valid;
    logic          req0_ready;
    logic [XW-1:0] req0_x;
    logic [YW-1:0] req0_y;
    logic [CW-1:0] req0_color;

    logic          req1_valid;
    logic          req1_ready;
    logic [XW-1:0] req1_x;
    logic [YW-1:0] req1_y;
    logic [CW-1:0] req1_color;

    logic [XW-1:0] VGA_x;
    logic [YW-1:0] VGA_y;
    logic [CW-1:0] VGA_color;
    logic          VGA_write;

    modport master (
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        input  req0_ready, req1_ready,
        input  VGA_x, VGA_y, VGA_color, VGA_write
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        output req0_ready, req1_ready,
        output VGA_x, VGA_y, VGA_color, VGA_write
    );

endinterface

// File: rtl/vga_plot_arbiter_clear_scanner.sv
// clear_scanner: raster counter for the screen clear.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       begin a scan; the counter steps past (0,0) on this edge
//   enable      keep scanning while busy
//   x, y        current raster position (x inner loop, y outer loop)
//   last        position is the final pixel (XMAX-1, YMAX-1)
//   busy        a scan is in progress
// The counter rests at (0,0) between scans, so the pixel presented while
// start is high is always (0,0).
module clear_scanner
    import vga_plot_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last,
    output logic          busy
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          busy_q, busy_d;
    logic          advance_s;
    logic          last_s;

    assign last_s = (x_q == X_LAST) && (y_q == Y_LAST);

    // Next raster position and busy flag; wrap is explicit at the frame edge.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        busy_d    = busy_q;
        advance_s = start || (busy_q && enable);
        if (advance_s) begin
            if (x_q == X_LAST) begin
                x_d = {XW{1'b0}};
                if (y_q == Y_LAST) begin
                    y_d = {YW{1'b0}};
                end else begin
                    y_d = y_q + 7'd1;
                end
            end else begin
                x_d = x_q + 8'd1;
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
        if (start) begin
            busy_d = 1'b1;
        end else if (busy_q && enable && last_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Counter and busy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= {XW{1'b0}};
            y_q    <= {YW{1'b0}};
            busy_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            busy_q <= busy_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = last_s;
    assign busy = busy_q;

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the frame-buffer write port between the snake
// requester (req0) and the overlay requester (req1), with a built-in
// full-screen clear that has absolute priority.
//   CLOCK_50   rising-edge clock
//   reset      synchronous, active-high
//   clr_start  pulse: start a clear; clr_busy/clr_done report progress
//   oob_err    sticky: an out-of-frame request was accepted
//   bus        requester handshakes and registered VGA write outputs
// A handshake or clear pixel selected before an edge appears on the VGA
// outputs after that edge, giving one pixel per cycle.
module vga_plot_arbiter
    import vga_plot_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               oob_err,
    vga_plot_arbiter_if.slave  bus
);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;          // 1: req1 is favoured on a tie
    logic [XW-1:0] vga_x_q, vga_x_d;
    logic [YW-1:0] vga_y_q, vga_y_d;
    logic [CW-1:0] vga_color_q, vga_color_d;
    logic          vga_write_q, vga_write_d;
    logic          clr_busy_q, clr_busy_d;
    logic          last_write_q, last_write_d;
    logic          clr_done_q, clr_done_d;
    logic          oob_q, oob_d;

    logic          clear_start_s, clear_emit_s, arb_en_s;
    logic          grant0_s, grant1_s;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic          scan_last, scan_busy;

    clear_scanner u_scan (
        .clk    (CLOCK_50),
        .reset  (reset),
        .start  (clear_start_s),
        .enable (state_q == S_CLEAR),
        .x      (scan_x),
        .y      (scan_y),
        .last   (scan_last),
        .busy   (scan_busy)
    );

    // Clear launch and round-robin grants. Grants are withheld while a clear
    // is starting or its writes are still draining through the output stage.
    always_comb begin
        clear_start_s = (state_q == S_IDLE) && clr_start;
        clear_emit_s  = clear_start_s || (state_q == S_CLEAR);
        arb_en_s      = (state_q == S_IDLE) && !clr_start && !clr_busy_q && !reset;
        grant0_s      = arb_en_s && bus.req0_valid && (!bus.req1_valid || !ptr_q);
        grant1_s      = arb_en_s && bus.req1_valid && (!bus.req0_valid || ptr_q);
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (scan_last || !scan_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output stage, pointer and status flags.
    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_color_d  = vga_color_q;
        vga_write_d  = 1'b0;
        ptr_d        = ptr_q;
        oob_d        = oob_q;
        clr_busy_d   = clear_emit_s;
        // clr_done trails the last clear write by one cycle.
        last_write_d = (state_q == S_CLEAR) && scan_last;
        clr_done_d   = last_write_q;
        if (clear_emit_s) begin
            vga_x_d     = scan_x;
            vga_y_d     = scan_y;
            vga_color_d = BG_COLOR;
            vga_write_d = 1'b1;
        end else if (grant0_s) begin
            ptr_d = 1'b1;
            if (in_range(bus.req0_x, bus.req0_y)) begin
                vga_x_d     = bus.req0_x;
                vga_y_d     = bus.req0_y;
                vga_color_d = bus.req0_color;
                vga_write_d = 1'b1;
            end else begin
                oob_d = 1'b1;
            end
        end else if (grant1_s) begin
            ptr_d = 1'b0;
            if (in_range(bus.req1_x, bus.req1_y)) begin
                vga_x_d     = bus.req1_x;
                vga_y_d     = bus.req1_y;
                vga_color_d = bus.req1_color;
                vga_write_d = 1'b1;
            end else begin
                oob_d = 1'b1;
            end
        end else begin
            vga_write_d = 1'b0;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            vga_x_q      <= {XW{1'b0}};
            vga_y_q      <= {YW{1'b0}};
            vga_color_q  <= {CW{1'b0}};
            vga_write_q  <= 1'b0;
            clr_busy_q   <= 1'b0;
            last_write_q <= 1'b0;
            clr_done_q   <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_color_q  <= vga_color_d;
            vga_write_q  <= vga_write_d;
            clr_busy_q   <= clr_busy_d;
            last_write_q <= last_write_d;
            clr_done_q   <= clr_done_d;
            oob_q        <= oob_d;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.VGA_x      = vga_x_q;
    assign bus.VGA_y      = vga_y_q;
    assign bus.VGA_color  = vga_color_q;
    assign bus.VGA_write  = vga_write_q;
    assign clr_busy       = clr_busy_q;
    assign clr_done       = clr_done_q;
    assign oob_err        = oob_q;

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
Shares the single pixel-write port (VGA_x, VGA_y, VGA_color, VGA_write) of the 160x120, 9-bit-colour frame buffer between two drawing requesters: req0 (snake body/head) and req1 (food/score overlay).
Contains a built-in screen-clear sequencer that fills the frame with a background colour and takes absolute priority over both requesters.
Sits between the game logic and the VGA adapter inside vga_demo.

Parameters:
XMAX, 160, horizontal pixel count
YMAX, 120, vertical pixel count
XW, 8, x coordinate width
YW, 7, y coordinate width
CW, 9, colour width (3 bits per channel)
BG_COLOR, 9'h000, clear-fill colour

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
clr_start  in  1  single-cycle pulse; requests a full-screen clear
clr_busy  out  1  high while a clear is in progress
clr_done  out  1  single-cycle pulse when a clear completes
req0_valid  in  1  snake pixel request
req0_ready  out  1  grant/accept for req0
req0_x  in  XW  snake pixel x
req0_y  in  YW  snake pixel y
req0_color  in  CW  snake pixel colour
req1_valid  in  1  overlay pixel request
req1_ready  out  1  grant/accept for req1
req1_x  in  XW  overlay pixel x
req1_y  in  YW  overlay pixel y
req1_color  in  CW  overlay pixel colour
VGA_x  out  XW  registered write x
VGA_y  out  YW  registered write y
VGA_color  out  CW  registered write colour
VGA_write  out  1  registered write strobe
oob_err  out  1  sticky: an out-of-range request was accepted

Behaviour:
- Reset: state IDLE; all outputs 0; clear counters 0; round-robin pointer favours req0. Reset during a clear aborts it with no clr_done pulse.
- FSM states:
  - IDLE/ARB: arbitrate requests.
  - CLEAR: run the clear scan.
- IDLE --clr_start--> CLEAR on the next edge. clr_start is ignored while in CLEAR.
- CLEAR --last pixel--> IDLE.
- CLEAR scan:
  - x increments 0..XMAX-1 as the inner loop; y increments 0..YMAX-1 as the outer loop.
  - One pixel per cycle: VGA_write=1, VGA_color=BG_COLOR.
  - Total XMAX*YMAX = 19200 write cycles.
  - clr_busy=1 from the cycle after clr_start through the cycle carrying the last write (x=159, y=119).
  - clr_done pulses for 1 cycle on the cycle after that last write.
- During CLEAR, req0_ready = req1_ready = 0; requesters hold valid and data stable.
- Arbitration (IDLE only):
  - req*_ready is combinational from valid and the pointer; at most one ready is high per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted most recently is granted. The pointer updates only on a transfer.
  - A transfer is valid && ready at the rising edge.
- Latency: the handshake at edge N produces VGA_x/y/color loaded and VGA_write=1 after edge N. This gives a sustained throughput of 1 pixel/cycle. VGA_write=0 in any cycle with no transfer; VGA_x/y/color hold their last values.
- clr_start arriving in the same cycle as a valid request: clear wins. Both ready signals are forced 0 that cycle, so no transfer occurs.
- Out-of-range request (x >= XMAX or y >= YMAX):
  - Still accepted (ready as normal) and the pointer advances.
  - Not written: VGA_write=0.
  - oob_err sets and stays set until reset.
- The clear counters use natural XW/YW widths. Wrap is explicit at XMAX-1 and YMAX-1, not modulo 2^W.

Decomposition:
- Package vga_plot_pkg holds: XMAX, YMAX, XW, YW, CW, BG_COLOR defaults, and the state encoding localparams (S_IDLE, S_CLEAR).
- Sub-module clear_scanner contains:
  - the x/y raster counter, with inputs start and enable;
  - outputs x, y, last, busy.
- The arbiter, pointer, output register and FSM stay in the top.

Test Plan:
- Reset, then idle 10 cycles -> VGA_write=0, ready signals 0, clr_busy=0, oob_err=0.
- req0 alone, (10,20,9'h1C0) held valid 1 cycle -> req0_ready=1; next cycle VGA_x=10, VGA_y=20, VGA_color=9'h1C0, VGA_write=1, then VGA_write=0.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; VGA_write=1 on 6 consecutive cycles.
- clr_start pulse with req1 pending -> req1_ready=0 for the whole clear:
  - exactly 19200 writes of 9'h000;
  - first write (0,0), last write (159,119);
  - clr_done pulses once;
  - req1 is then granted on the cycle after clr_busy falls.
- req0 at (160,5) -> accepted, no VGA_write, oob_err=1 and stays 1; a following valid request writes normally.
- Assert reset at clear pixel 5000 -> next cycle clr_busy=0, VGA_write=0, no clr_done; a new clr_start restarts the scan at (0,0).
